// File: rtl/axis_hfilter_3tap.sv
// Horizontal [1 2 1]/4 smoothing filter for grayscale AXI-Stream video.
// Rows are edge-replicated at both ends, so output geometry and sideband match the input.
module axis_hfilter_3tap #(
    parameter int PIXEL_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [PIXEL_BITS-1:0] axis_s_data_i,
    input  logic                  axis_s_valid_i,
    output logic                  axis_s_ready_o,
    input  logic                  axis_s_last_i,
    input  logic                  axis_s_user_i,
    output logic [PIXEL_BITS-1:0] axis_m_data_o,
    output logic                  axis_m_valid_o,
    input  logic                  axis_m_ready_i,
    output logic                  axis_m_last_o,
    output logic                  axis_m_user_o
);

    localparam int SW = PIXEL_BITS + 2;

    typedef enum logic [1:0] {
        ROW_START = 2'd0,
        ROW       = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    state_t                state_reg;
    logic [PIXEL_BITS-1:0] cur_reg;
    logic [PIXEL_BITS-1:0] prv_reg;
    logic                  cur_user_reg;
    logic [PIXEL_BITS-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic                  out_user_reg;

    logic                  slot_free;
    logic                  accept;
    logic [SW-1:0]         sum_row;
    logic [SW-1:0]         sum_flush;

    assign slot_free      = !out_valid_reg || axis_m_ready_i;
    assign axis_s_ready_o = rstn_i && slot_free && (state_reg != FLUSH);
    assign accept         = axis_s_valid_i && axis_s_ready_o;

    // Two guard bits make the weighted sum overflow-free; +2 rounds half up.
    assign sum_row   = SW'(prv_reg) + (SW'(cur_reg) << 1) + SW'(axis_s_data_i) + SW'(2);
    assign sum_flush = SW'(prv_reg) + (SW'(cur_reg) << 1) + SW'(cur_reg) + SW'(2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= ROW_START;
            cur_reg       <= '0;
            prv_reg       <= '0;
            cur_user_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_user_reg  <= 1'b0;
        end else begin
            if (out_valid_reg && axis_m_ready_i) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ROW_START: begin
                    if (accept) begin
                        cur_reg      <= axis_s_data_i;
                        prv_reg      <= axis_s_data_i;
                        cur_user_reg <= axis_s_user_i;
                        state_reg    <= axis_s_last_i ? FLUSH : ROW;
                    end
                end
                ROW: begin
                    if (accept) begin
                        out_data_reg  <= sum_row[SW-1:2];
                        out_user_reg  <= cur_user_reg;
                        out_last_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        prv_reg       <= cur_reg;
                        cur_reg       <= axis_s_data_i;
                        cur_user_reg  <= axis_s_user_i;
                        if (axis_s_last_i) begin
                            state_reg <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Right edge: the missing neighbour is the final pixel itself.
                    if (slot_free) begin
                        out_data_reg  <= sum_flush[SW-1:2];
                        out_user_reg  <= cur_user_reg;
                        out_last_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ROW_START;
                    end
                end
                default: begin
                    state_reg <= ROW_START;
                end
            endcase
        end
    end

    assign axis_m_data_o  = out_data_reg;
    assign axis_m_valid_o = out_valid_reg;
    assign axis_m_last_o  = out_last_reg;
    assign axis_m_user_o  = out_user_reg;

endmodule

// File: tb/tb_axis_hfilter_3tap.sv
// Bench for axis_hfilter_3tap: whole-row reference model, per-cycle output checker, directed rows.
module tb_axis_hfilter_3tap;

    localparam int P = 8;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [P-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic         s_user;
    logic [P-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         m_user;

    always #5 clk_i = ~clk_i;

    axis_hfilter_3tap #(.PIXEL_BITS(P)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .axis_s_data_i  (s_data),
        .axis_s_valid_i (s_valid),
        .axis_s_ready_o (s_ready),
        .axis_s_last_i  (s_last),
        .axis_s_user_i  (s_user),
        .axis_m_data_o  (m_data),
        .axis_m_valid_o (m_valid),
        .axis_m_ready_i (m_ready),
        .axis_m_last_o  (m_last),
        .axis_m_user_o  (m_user)
    );

    int vectors = 0;
    int miscompares = 0;
    int bubbles = 0;

    int exp_d[$];
    bit exp_u[$];
    bit exp_l[$];
    int obs_d[$];
    int obs_u[$];
    int obs_l[$];

    int row_px[16];
    bit row_us[16];

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int obs_at(input int kind, input int i);
        if (i < 0 || i >= obs_d.size()) return -1;
        case (kind)
            0:       return obs_d[i];
            1:       return obs_u[i];
            default: return obs_l[i];
        endcase
    endfunction

    // Reference: each output is the [1 2 1] kernel over the row with replicated ends.
    task automatic model_row(input int n);
        int l, r;
        for (int i = 0; i < n; i++) begin
            l = (i == 0) ? row_px[0] : row_px[i-1];
            r = (i == n - 1) ? row_px[n-1] : row_px[i+1];
            exp_d.push_back((l + 2 * row_px[i] + r + 2) / 4);
            exp_u.push_back(row_us[i]);
            exp_l.push_back(i == n - 1);
        end
    endtask

    task automatic monitor();
        bit stalled = 0;
        int sd = 0;
        int su = 0;
        int sl = 0;
        int ed;
        bit eu, el;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", int'(m_valid), 1);
                    chk("hold_data", int'(m_data), sd);
                    chk("hold_user", int'(m_user), su);
                    chk("hold_last", int'(m_last), sl);
                end
                if (m_valid && !m_ready) begin
                    chk("stall_s_ready", int'(s_ready), 0);
                    stalled = 1;
                    sd = int'(m_data);
                    su = int'(m_user);
                    sl = int'(m_last);
                end else begin
                    stalled = 0;
                end
                if (!s_ready) bubbles++;
                if (m_valid && m_ready) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_output", int'(m_data), -1);
                    end else begin
                        ed = exp_d.pop_front();
                        eu = exp_u.pop_front();
                        el = exp_l.pop_front();
                        chk("out_data", int'(m_data), ed);
                        chk("out_user", int'(m_user), int'(eu));
                        chk("out_last", int'(m_last), int'(el));
                    end
                    obs_d.push_back(int'(m_data));
                    obs_u.push_back(int'(m_user));
                    obs_l.push_back(int'(m_last));
                end
            end
        end
    endtask

    task automatic send_pix(input int d, input bit u, input bit l);
        int waited = 0;
        s_data  = P'(d);
        s_user  = u;
        s_last  = l;
        s_valid = 1'b1;
        @(negedge clk_i);
        while (!s_ready && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got s_ready=0 for 100 cycles, required 1");
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_row(input int n, input bit keep_valid);
        model_row(n);
        for (int i = 0; i < n; i++) begin
            send_pix(row_px[i], row_us[i], i == n - 1);
        end
        if (!keep_valid) s_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_d.size() != 0 || m_valid) && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        @(posedge clk_i);
        #1;
        chk("expected_queue_empty", exp_d.size(), 0);
    endtask

    task automatic set_row(input int n, input int a0, input int a1, input int a2, input int a3,
                           input int a4, input bit u0);
        int v[5];
        v = '{a0, a1, a2, a3, a4};
        for (int i = 0; i < n; i++) begin
            row_px[i] = (i < 5) ? v[i] : v[4];
            row_us[i] = (i == 0) ? u0 : 1'b0;
        end
    endtask

    initial begin
        int base;
        int waited;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        m_ready = 1'b1;
        rstn_i  = 1'b0;
        fork
            monitor();
        join_none

        #1;
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_data", int'(m_data), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_m_user", int'(m_user), 0);
        chk("reset_s_ready", int'(s_ready), 0);
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Row 10,20,30,40
        base = obs_d.size();
        bubbles = 0;
        set_row(4, 10, 20, 30, 40, 40, 1'b1);
        send_row(4, 1'b0);
        drain();
        chk("t1_bubbles", bubbles, 1);
        chk("t1_out0", obs_at(0, base), 13);
        chk("t1_out1", obs_at(0, base + 1), 20);
        chk("t1_out2", obs_at(0, base + 2), 30);
        chk("t1_out3", obs_at(0, base + 3), 38);
        chk("t1_user0", obs_at(1, base), 1);
        chk("t1_user1", obs_at(1, base + 1), 0);
        chk("t1_last2", obs_at(2, base + 2), 0);
        chk("t1_last3", obs_at(2, base + 3), 1);

        // Single-pixel row, then a fresh row
        base = obs_d.size();
        set_row(1, 200, 0, 0, 0, 0, 1'b1);
        send_row(1, 1'b0);
        set_row(2, 100, 60, 0, 0, 0, 1'b0);
        send_row(2, 1'b0);
        drain();
        chk("t2_single_data", obs_at(0, base), 200);
        chk("t2_single_user", obs_at(1, base), 1);
        chk("t2_single_last", obs_at(2, base), 1);
        chk("t2_next0", obs_at(0, base + 1), 90);
        chk("t2_next1", obs_at(0, base + 2), 70);

        // Eight full-scale pixels
        base = obs_d.size();
        set_row(8, 255, 255, 255, 255, 255, 1'b1);
        send_row(8, 1'b0);
        drain();
        for (int i = 0; i < 8; i++) chk("t3_sat_data", obs_at(0, base + i), 255);
        chk("t3_last7", obs_at(2, base + 7), 1);
        chk("t3_last6", obs_at(2, base + 6), 0);

        // Backpressure for 5 cycles after the 2nd output
        base = obs_d.size();
        set_row(5, 0, 0, 100, 0, 0, 1'b1);
        fork
            send_row(5, 1'b0);
            begin
                waited = 0;
                do begin
                    @(posedge clk_i);
                    waited++;
                end while (obs_d.size() < base + 2 && waited < 100);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge clk_i);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        chk("t4_out0", obs_at(0, base), 0);
        chk("t4_out1", obs_at(0, base + 1), 25);
        chk("t4_out2", obs_at(0, base + 2), 50);
        chk("t4_out3", obs_at(0, base + 3), 25);
        chk("t4_out4", obs_at(0, base + 4), 0);

        // Two back-to-back rows with continuous valid
        base = obs_d.size();
        bubbles = 0;
        set_row(4, 1, 2, 3, 4, 4, 1'b1);
        send_row(4, 1'b1);
        set_row(4, 8, 8, 8, 8, 8, 1'b0);
        send_row(4, 1'b0);
        drain();
        chk("t5_bubbles", bubbles, 2);
        chk("t5_count", obs_d.size() - base, 8);
        chk("t5_out0", obs_at(0, base), 1);
        chk("t5_out3", obs_at(0, base + 3), 4);
        chk("t5_last3", obs_at(2, base + 3), 1);
        chk("t5_last7", obs_at(2, base + 7), 1);
        chk("t5_last5", obs_at(2, base + 5), 0);

        // Reset in the middle of a row with an output pending
        m_ready = 1'b0;
        send_pix(10, 1'b1, 1'b0);
        send_pix(20, 1'b0, 1'b0);
        s_valid = 1'b0;
        chk("t6_pending_valid", int'(m_valid), 1);
        rstn_i = 1'b0;
        #1;
        chk("t6_reset_m_valid", int'(m_valid), 0);
        chk("t6_reset_m_data", int'(m_data), 0);
        chk("t6_reset_s_ready", int'(s_ready), 0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        m_ready = 1'b1;
        base = obs_d.size();
        set_row(2, 50, 50, 0, 0, 0, 1'b1);
        send_row(2, 1'b0);
        drain();
        chk("t6_count", obs_d.size() - base, 2);
        chk("t6_out0", obs_at(0, base), 50);
        chk("t6_out1", obs_at(0, base + 1), 50);
        chk("t6_last0", obs_at(2, base), 0);
        chk("t6_last1", obs_at(2, base + 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
